// File: rtl/e_contract.sv
// Inverse DES E-box: rebuilds the 32-bit half-block from a 48-bit expanded word, flags inconsistent edge bits.
// Results queue in a DEPTH-entry FIFO (1-cycle latency, no in->out comb path); in_ready drops only when full.
module e_contract #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:47]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:31]      out_data,
    output logic             out_err,
    output logic [0:7]       out_mask,
    output logic [CNT_W-1:0] err_count,
    input  logic             cnt_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [0:31]   d;
    logic [0:7]    mask;
    logic          err;
    logic          push;
    logic          pop;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [0:31]   data_mem [DEPTH];
    logic [0:7]    mask_mem [DEPTH];

    // Each group carries 4 data bits flanked by copies of its neighbours' edge data bits.
    for (genvar k = 0; k < 8; k++) begin : g_grp
        assign d[4*k +: 4] = in_data[6*k+1 +: 4];
        assign mask[k] = (in_data[6*k]   != in_data[6*((k+7)%8)+4]) |
                         (in_data[6*k+5] != in_data[6*((k+1)%8)+1]);
    end

    assign err       = |mask;
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head is read straight from storage; gating with out_valid keeps stale entries invisible after reset.
    assign out_data = out_valid ? data_mem[rd_ptr] : '0;
    assign out_mask = out_valid ? mask_mem[rd_ptr] : '0;
    assign out_err  = |out_mask;

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= d;
            mask_mem[wr_ptr] <= mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            err_count <= '0;
        end else if (push && err && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_e_contract.sv
// Bench for e_contract: directed vectors plus a queue model of the FIFO checked every cycle.
module tb_e_contract;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [0:47]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [0:31]      out_data;
    logic             out_err;
    logic [0:7]       out_mask;
    logic [CNT_W-1:0] err_count;
    logic             cnt_clr;

    e_contract #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_mask  (out_mask),
        .err_count (err_count),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit run_chk = 1'b0;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  m;
    } exp_t;

    exp_t q[$];
    int   cnt_m = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Forward DES E-box, straight from the expansion rule.
    function automatic logic [0:47] expand(input logic [0:31] dd);
        logic [0:47] e;
        for (int k = 0; k < 8; k++) begin
            e[6*k] = dd[(4*k + 31) % 32];
            for (int j = 0; j < 4; j++) e[6*k+1+j] = dd[4*k+j];
            e[6*k+5] = dd[(4*k + 4) % 32];
        end
        return e;
    endfunction

    // Take the data bits, re-expand them, and flag any group whose edges disagree.
    function automatic exp_t contract(input logic [0:47] e);
        logic [0:31] dd;
        logic [0:47] ee;
        logic [0:7]  mm;
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 4; j++) dd[4*k+j] = e[6*k+1+j];
        ee = expand(dd);
        for (int k = 0; k < 8; k++)
            mm[k] = (e[6*k] != ee[6*k]) || (e[6*k+5] != ee[6*k+5]);
        return '{d: dd, m: mm};
    endfunction

    always @(posedge clk) begin : model
        bit   do_push;
        bit   do_pop;
        exp_t r;
        if (rst) begin
            q.delete();
            cnt_m = 0;
        end else begin
            do_push = in_valid && (q.size() < DEPTH);
            do_pop  = out_ready && (q.size() != 0);
            r = contract(in_data);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(r);
            if (cnt_clr) cnt_m = 0;
            else if (do_push && (r.m != 0) && cnt_m < (2**CNT_W - 1)) cnt_m++;
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            check("out_valid", out_valid, q.size() != 0);
            check("in_ready", in_ready, q.size() < DEPTH);
            check("err_count", err_count, cnt_m);
            if (q.size() != 0) begin
                check("out_data", out_data, q[0].d);
                check("out_mask", out_mask, q[0].m);
                check("out_err", out_err, q[0].m != 0);
            end
        end
    end

    task automatic push_word(input logic [0:47] e);
        int n = 0;
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = e;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 20);
        in_valid = 1'b0;
        check("accept", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam logic [0:47] E_WRAP = 48'h400000000001;
    localparam logic [0:47] E_BAD  = 48'h400000000000;

    initial begin
        exp_t pin;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst in_ready", in_ready, 1'b1);
        check("rst out_valid", out_valid, 1'b0);
        check("rst out_data", out_data, 32'h0);
        check("rst out_err", out_err, 1'b0);
        check("rst out_mask", out_mask, 8'h00);
        check("rst err_count", err_count, 4'h0);
        run_chk = 1'b1;

        // model pins
        pin = contract(E_WRAP);
        check("model wrap d", pin.d, 32'h80000000);
        check("model wrap m", pin.m, 8'h00);
        pin = contract(E_BAD);
        check("model bad m", pin.m, 8'h01);
        check("model expand", expand(32'h80000000), E_WRAP);

        // basic
        @(posedge clk); #1;
        push_word(48'h000000000000);
        @(negedge clk);
        check("basic0 valid", out_valid, 1'b1);
        check("basic0 data", out_data, 32'h00000000);
        check("basic0 err", out_err, 1'b0);
        @(posedge clk); #1;
        push_word(48'hFFFFFFFFFFFF);
        @(negedge clk);
        check("basic1 valid", out_valid, 1'b1);
        check("basic1 data", out_data, 32'hFFFFFFFF);
        check("basic1 err", out_err, 1'b0);
        idle(2);

        // wrap-around edge bits
        push_word(E_WRAP);
        @(negedge clk);
        check("wrap data", out_data, 32'h80000000);
        check("wrap mask", out_mask, 8'h00);
        @(posedge clk); #1;
        push_word(E_BAD);
        @(negedge clk);
        check("bad data", out_data, 32'h80000000);
        check("bad err", out_err, 1'b1);
        check("bad mask", out_mask, 8'h01);
        check("bad count", err_count, 4'h1);
        idle(2);

        // fill and backpressure
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(expand(32'h11111111 * (i + 1)));
        @(negedge clk);
        check("full in_ready", in_ready, 1'b0);
        in_valid = 1'b1;
        in_data  = expand(32'hCAFEF00D);
        idle(3);
        @(negedge clk);
        check("full hold ready", in_ready, 1'b0);
        check("full head", out_data, 32'h11111111);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(4);
        @(negedge clk);
        check("drain ready", in_ready, 1'b1);
        check("drain valid", out_valid, 1'b0);
        @(posedge clk); #1;

        // concurrent push/pop at occupancy 2
        out_ready = 1'b0;
        push_word(expand(32'hA5A5A5A5));
        push_word(expand(32'h5A5A5A5A));
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = {$urandom(), $urandom_range(65535, 0)};
        repeat (10) begin
            @(negedge clk);
            check("occ2 valid", out_valid, 1'b1);
            check("occ2 ready", in_ready, 1'b1);
            @(posedge clk); #1;
            in_data = {$urandom(), $urandom_range(65535, 0)};
        end
        in_valid = 1'b0;
        idle(3);

        // saturating counter
        cnt_clr = 1'b1;
        idle(1);
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr count", err_count, 4'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) push_word(E_BAD);
        @(negedge clk);
        check("sat count", err_count, 4'hF);
        @(posedge clk); #1;
        cnt_clr = 1'b1;
        push_word(E_BAD);
        cnt_clr = 1'b0;
        @(negedge clk);
        check("clr prio", err_count, 4'h0);
        idle(2);

        // reset with words queued
        out_ready = 1'b0;
        push_word(expand(32'h01234567));
        push_word(E_BAD);
        push_word(expand(32'h89ABCDEF));
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("mid-rst valid", out_valid, 1'b0);
        check("mid-rst count", err_count, 4'h0);
        check("mid-rst ready", in_ready, 1'b1);
        @(posedge clk); #1;
        push_word(expand(32'hDEADBEEF));
        @(negedge clk);
        check("post-rst first", out_data, 32'hDEADBEEF);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(3);

        run_chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
